// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and slot constants for the tdm_demux4 receiver
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int SLOTS = 4;

    typedef logic [1:0] slot_t;

    // Slot index to lane mapping, identical to the transmit mux select encoding
    localparam slot_t SLOT_A = 2'd0;
    localparam slot_t SLOT_B = 2'd1;
    localparam slot_t SLOT_C = 2'd2;
    localparam slot_t SLOT_D = 2'd3;

endpackage

// File: rtl/tdm_sync_fsm.sv
// rtl/tdm_sync_fsm.sv - frame alignment FSM: slot counter, store/commit strobes, sync_err
module tdm_sync_fsm
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid,
    input  logic  sof,
    output slot_t slot,
    output logic  store,
    output slot_t store_slot,
    output logic  commit,
    output logic  sync_err
);

    state_t state;

    // A beat with sof always restarts the frame at slot 0, locked or not
    always_comb begin
        store      = 1'b0;
        store_slot = slot;
        commit     = 1'b0;
        if (in_valid) begin
            if (sof) begin
                store      = 1'b1;
                store_slot = SLOT_A;
            end else if (state == LOCKED && slot != SLOT_A) begin
                store  = 1'b1;
                commit = (slot == SLOT_D);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HUNT;
            slot     <= SLOT_A;
            sync_err <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            if (in_valid) begin
                if (sof) begin
                    sync_err <= (state == LOCKED) && (slot != SLOT_A);
                    state    <= LOCKED;
                    slot     <= SLOT_B;
                end else if (state == LOCKED) begin
                    if (slot == SLOT_A) begin
                        sync_err <= 1'b1;
                        state    <= HUNT;
                    end else begin
                        slot <= slot + slot_t'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 1:4 TDM demux with sof alignment; TDM_DEMUX_STATS_EN adds frame/error counters
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] din,
    input  logic             sof,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             s1,
    output logic             s2,
    output logic             frame_valid,
    output logic             sync_err
`ifdef TDM_DEMUX_STATS_EN
    ,
    output logic [15:0]      frame_cnt,
    output logic [7:0]       err_cnt
`endif
);

    slot_t            slot;
    slot_t            store_slot;
    logic             store;
    logic             commit;
    logic [WIDTH-1:0] shadow0;
    logic [WIDTH-1:0] shadow1;
    logic [WIDTH-1:0] shadow2;

    tdm_sync_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .sof        (sof),
        .slot       (slot),
        .store      (store),
        .store_slot (store_slot),
        .commit     (commit),
        .sync_err   (sync_err)
    );

    assign s1 = slot[1];
    assign s2 = slot[0];

    // The slot-3 beat goes straight to d, so only three shadow registers exist
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow0     <= '0;
            shadow1     <= '0;
            shadow2     <= '0;
            a           <= '0;
            b           <= '0;
            c           <= '0;
            d           <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= commit;
            if (store && !commit) begin
                case (store_slot)
                    SLOT_A:  shadow0 <= din;
                    SLOT_B:  shadow1 <= din;
                    SLOT_C:  shadow2 <= din;
                    default: ;
                endcase
            end
            if (commit) begin
                a <= shadow0;
                b <= shadow1;
                c <= shadow2;
                d <= din;
            end
        end
    end

`ifdef TDM_DEMUX_STATS_EN
    // Counters follow the registered pulses, so they settle one cycle after them
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (frame_valid)
                frame_cnt <= frame_cnt + 16'd1;
            if (sync_err && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - scoreboard bench for tdm_demux4 (WIDTH=8)
module tb_tdm_demux4;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         sof = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] a, b, c, d;
    logic         s1, s2, frame_valid, sync_err;
`ifdef TDM_DEMUX_STATS_EN
    logic [15:0]  frame_cnt;
    logic [7:0]   err_cnt;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int fv_seen = 0;
    int err_seen = 0;
    logic [4*W-1:0] exp_q[$];
    int fv_cyc[$];

    always #5 clk = ~clk;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .din         (din),
        .sof         (sof),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .s1          (s1),
        .s2          (s2),
        .frame_valid (frame_valid),
        .sync_err    (sync_err)
`ifdef TDM_DEMUX_STATS_EN
        ,
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
`endif
    );

    task automatic tick();
        logic [4*W-1:0] e;
        @(posedge clk);
        #2;
        cyc++;
        if (sync_err) err_seen++;
        if (frame_valid) begin
            fv_seen++;
            fv_cyc.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL frame_unexpected: got %h, required no frame", {a, b, c, d});
            end else begin
                e = exp_q.pop_front();
                if ({a, b, c, d} !== e) begin
                    n_fail++;
                    $display("FAIL frame_data: got %h, required %h", {a, b, c, d}, e);
                end
            end
        end
    endtask

    task automatic beat(input logic [W-1:0] v, input logic s);
        in_valid = 1'b1;
        din = v;
        sof = s;
        tick();
        in_valid = 1'b0;
        sof = 1'b0;
        din = '0;
    endtask

    task automatic frame(input logic [4*W-1:0] f);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) exp_q.push_back(f);
            beat(f[(3-k)*W +: W], k == 0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if ({a, b, c, d} !== '0) begin n_fail++; $display("FAIL reset_lanes: got %h, required 0", {a, b, c, d}); end
        n_checks++;
        if ({s1, s2} !== 2'b00) begin n_fail++; $display("FAIL reset_slot: got %b, required 00", {s1, s2}); end
        n_checks++;
        if ({frame_valid, sync_err} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b, required 00", {frame_valid, sync_err}); end
    endtask

    task automatic test_single();
        logic [4*W-1:0] f;
        int f0;
        f = {8'h01, 8'h00, 8'h00, 8'h00};
        f0 = fv_seen;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({s1, s2} !== 2'(k)) begin n_fail++; $display("FAIL single_slot%0d: got %b, required %0d", k, {s1, s2}, k); end
            if (k == 3) exp_q.push_back(f);
            beat(f[(3-k)*W +: W], k == 0);
        end
        n_checks++;
        if (fv_seen != f0 + 1) begin n_fail++; $display("FAIL single_fv_count: got %0d, required 1", fv_seen - f0); end
        n_checks++;
        if ({s1, s2} !== 2'b00) begin n_fail++; $display("FAIL single_wrap: got %b, required 00", {s1, s2}); end
    endtask

    task automatic test_back_to_back();
        logic [4*W-1:0] f;
        int f0, n0;
        f0 = fv_seen;
        n0 = fv_cyc.size();
        for (int i = 0; i < 4; i++) begin
            f = '0;
            f[(3-i)*W +: W] = 8'h01;
            frame(f);
        end
        n_checks++;
        if (fv_seen != f0 + 4) begin n_fail++; $display("FAIL b2b_fv_count: got %0d, required 4", fv_seen - f0); end
        else begin
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (fv_cyc[n0+i] - fv_cyc[n0+i-1] != 4) begin
                    n_fail++;
                    $display("FAIL b2b_spacing%0d: got %0d, required 4", i, fv_cyc[n0+i] - fv_cyc[n0+i-1]);
                end
            end
        end
    endtask

    task automatic test_gaps();
        logic [4*W-1:0] f;
        int f0;
        f = 32'h11223344;
        f0 = fv_seen;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) exp_q.push_back(f);
            beat(f[(3-k)*W +: W], k == 0);
            if (k < 3) begin
                for (int g = 0; g < 2; g++) begin
                    tick();
                    n_checks++;
                    if ({s1, s2} !== 2'(k + 1) || frame_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL gap_hold%0d: got slot %b fv %b, required slot %0d fv 0", k, {s1, s2}, frame_valid, k + 1);
                    end
                end
            end
        end
        tick();
        n_checks++;
        if (fv_seen != f0 + 1 || {a, b, c, d} !== 32'h11223344) begin
            n_fail++;
            $display("FAIL gap_frame: got %0d frames %h, required 1 frame 11223344", fv_seen - f0, {a, b, c, d});
        end
    endtask

    task automatic test_sof_mid();
        int e0;
        e0 = err_seen;
        beat(8'hA1, 1'b1);
        beat(8'hA2, 1'b0);
        beat(8'hB0, 1'b1);
        n_checks++;
        if (sync_err !== 1'b1) begin n_fail++; $display("FAIL sofmid_err: got %b, required 1", sync_err); end
        n_checks++;
        if ({a, b, c, d} !== 32'h11223344) begin n_fail++; $display("FAIL sofmid_hold: got %h, required 11223344", {a, b, c, d}); end
        n_checks++;
        if ({s1, s2} !== 2'b01) begin n_fail++; $display("FAIL sofmid_slot: got %b, required 01", {s1, s2}); end
        beat(8'hB1, 1'b0);
        n_checks++;
        if (sync_err !== 1'b0) begin n_fail++; $display("FAIL sofmid_pulse_len: got %b, required 0", sync_err); end
        beat(8'hB2, 1'b0);
        exp_q.push_back(32'hB0B1B2B3);
        beat(8'hB3, 1'b0);
        n_checks++;
        if (err_seen != e0 + 1) begin n_fail++; $display("FAIL sofmid_err_count: got %0d, required 1", err_seen - e0); end
    endtask

    task automatic test_hunt();
        int e0, f0;
        e0 = err_seen;
        f0 = fv_seen;
        beat(8'h55, 1'b0);
        n_checks++;
        if (sync_err !== 1'b1 || {s1, s2} !== 2'b00) begin
            n_fail++;
            $display("FAIL hunt_enter: got err %b slot %b, required err 1 slot 00", sync_err, {s1, s2});
        end
        beat(8'h66, 1'b0);
        beat(8'h77, 1'b0);
        n_checks++;
        if ({s1, s2} !== 2'b00 || err_seen != e0 + 1 || fv_seen != f0) begin
            n_fail++;
            $display("FAIL hunt_ignore: got slot %b errs %0d frames %0d, required slot 00 errs 1 frames 0", {s1, s2}, err_seen - e0, fv_seen - f0);
        end
        frame(32'h01020304);
    endtask

    task automatic test_reset_mid();
        beat(8'hC1, 1'b1);
        beat(8'hC2, 1'b0);
        n_checks++;
        if ({s1, s2} !== 2'b10) begin n_fail++; $display("FAIL rstmid_pre: got %b, required 10", {s1, s2}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({a, b, c, d, s1, s2, frame_valid, sync_err} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %h slot %b fv %b err %b, required all 0", {a, b, c, d}, {s1, s2}, frame_valid, sync_err);
        end
        beat(8'hD0, 1'b0);
        n_checks++;
        if ({s1, s2} !== 2'b00 || sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_hunt: got slot %b err %b, required slot 00 err 0", {s1, s2}, sync_err);
        end
        frame(32'hE1E2E3E4);
    endtask

`ifdef TDM_DEMUX_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (frame_cnt !== 16'd0 || err_cnt !== 8'd0) begin n_fail++; $display("FAIL stats_reset: got %0d/%0d, required 0/0", frame_cnt, err_cnt); end
        frame(32'h10203040);
        frame(32'h50607080);
        frame(32'h90A0B0C0);
        beat(8'h01, 1'b1);
        beat(8'h02, 1'b1);
        beat(8'h03, 1'b1);
        tick();
        tick();
        n_checks++;
        if (frame_cnt !== 16'd3 || err_cnt !== 8'd2) begin n_fail++; $display("FAIL stats_count: got %0d/%0d, required 3/2", frame_cnt, err_cnt); end
        for (int i = 0; i < 260; i++) beat(8'h00, 1'b1);
        tick();
        tick();
        n_checks++;
        if (err_cnt !== 8'hFF || frame_cnt !== 16'd3) begin n_fail++; $display("FAIL stats_saturate: got %0d/%0d, required 3/255", frame_cnt, err_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gaps();
        test_sof_mid();
        test_hunt();
        test_reset_mid();
`ifdef TDM_DEMUX_STATS_EN
        test_stats();
`endif
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d frames pending, required 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
